// File: rtl/sifh_zoom_controller.sv
// Two-pass coarse/fine ("zoom") histogram sequencer for the dTOF pixel back end.
// Pass 1 accumulates a coarse histogram and finds its peak bin. The fine TDC
// window is centred in that bin, and pass 2 accumulates and scans the fine histogram.
// Every output is a register loaded from the next-state decode, so each output
// follows the state the FSM is currently in.
// Handshake: start is sampled only in IDLE. hist_clr is a one-cycle request that
// is answered by a one-cycle hist_clr_done. hist_rd_data is consumed exactly one
// cycle after each hist_rd_en strobe, and there is no backpressure.
module sifh_zoom_controller #(
  parameter int NP       = 10,
  parameter int NB       = 4,
  parameter int CW       = 16,
  parameter int N_COARSE = 4,
  parameter int N_FINE   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          frame_tick,
  output logic          hist_clr,
  input  logic          hist_clr_done,
  output logic          hist_en,
  output logic          fine_mode,
  output logic [NP-1:0] win_lo,
  output logic [NP-1:0] win_hi,
  output logic          hist_rd_en,
  output logic [NB-1:0] hist_rd_addr,
  input  logic [CW-1:0] hist_rd_data,
  output logic [NB-1:0] peak_bin,
  output logic [CW-1:0] peak_cnt,
  output logic [NP-1:0] tof,
  output logic          tof_valid,
  output logic          no_target,
  output logic          done,
  output logic          busy,
  output logic [3:0]    dbg_state
);

  localparam int NBINS = 1 << NB;
  localparam int NMAX  = (N_COARSE > N_FINE) ? N_COARSE : N_FINE;
  localparam int FW    = $clog2(NMAX + 1);

  localparam logic [NB:0]   SCAN_LAST   = (NB+1)'(NBINS);
  localparam logic [FW-1:0] LAST_C      = FW'(N_COARSE - 1);
  localparam logic [FW-1:0] LAST_F      = FW'(N_FINE - 1);
  localparam logic [NP-1:0] HALF_COARSE = NP'(1 << (NP - NB - 1));
  localparam logic [NP-1:0] HALF_FINE   = NP'(1 << (NB - 1));
  localparam logic [NP-1:0] FINE_SPAN   = NP'(NBINS - 1);

  typedef enum logic [3:0] {
    IDLE, CLR_C, ACC_C, SRCH_C, CALC, CLR_F, ACC_F, SRCH_F, FIN
  } state_t;

  state_t        state, state_n;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic [NB:0]   scan_cnt, scan_cnt_n;
  logic          rd_vld;
  logic [NB-1:0] rd_idx;
  logic [CW-1:0] run_max, cand_max;
  logic [NB-1:0] run_bin, cand_bin;
  logic [NP-1:0] calc_lo;
  logic          in_acc, in_srch, in_acc_n, in_srch_n, in_clr_n, rd_en_n;

  assign dbg_state = state;

  // Next-state, counter and running-max decode.
  always_comb begin
    state_n     = state;
    frame_cnt_n = '0;
    scan_cnt_n  = '0;
    cand_max    = run_max;
    cand_bin    = run_bin;
    calc_lo     = (NP'(peak_bin) << (NP - NB)) + HALF_COARSE - HALF_FINE;
    in_acc      = (state == ACC_C) || (state == ACC_F);
    in_srch     = (state == SRCH_C) || (state == SRCH_F);

    if (rd_vld && (hist_rd_data > run_max)) begin
      cand_max = hist_rd_data;
      cand_bin = rd_idx;
    end

    case (state)
      IDLE:   if (start) state_n = CLR_C;
      CLR_C:  if (hist_clr_done) state_n = ACC_C;
      ACC_C:  if (frame_tick && (frame_cnt == LAST_C)) state_n = SRCH_C;
      SRCH_C: if (scan_cnt == SCAN_LAST) state_n = CALC;
      CALC:   state_n = (peak_cnt == '0) ? FIN : CLR_F;
      CLR_F:  if (hist_clr_done) state_n = ACC_F;
      ACC_F:  if (frame_tick && (frame_cnt == LAST_F)) state_n = SRCH_F;
      SRCH_F: if (scan_cnt == SCAN_LAST) state_n = FIN;
      FIN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;

    if (in_acc && (state_n == state)) frame_cnt_n = frame_cnt + FW'(frame_tick);
    if (in_srch && (state_n == state)) scan_cnt_n = scan_cnt + 1'b1;

    in_acc_n  = (state_n == ACC_C) || (state_n == ACC_F);
    in_srch_n = (state_n == SRCH_C) || (state_n == SRCH_F);
    in_clr_n  = (state_n == CLR_C) || (state_n == CLR_F);
    rd_en_n   = in_srch_n && (scan_cnt_n < SCAN_LAST);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      scan_cnt     <= '0;
      rd_vld       <= 1'b0;
      rd_idx       <= '0;
      run_max      <= '0;
      run_bin      <= '0;
      hist_clr     <= 1'b0;
      hist_en      <= 1'b0;
      fine_mode    <= 1'b0;
      win_lo       <= '0;
      win_hi       <= '0;
      hist_rd_en   <= 1'b0;
      hist_rd_addr <= '0;
      peak_bin     <= '0;
      peak_cnt     <= '0;
      tof          <= '0;
      tof_valid    <= 1'b0;
      no_target    <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      frame_cnt    <= frame_cnt_n;
      scan_cnt     <= scan_cnt_n;
      rd_vld       <= hist_rd_en;
      rd_idx       <= hist_rd_addr;
      hist_clr     <= in_clr_n && (state_n != state);
      hist_en      <= in_acc_n;
      fine_mode    <= (state_n == CLR_F) || (state_n == ACC_F) || (state_n == SRCH_F);
      hist_rd_en   <= rd_en_n;
      hist_rd_addr <= rd_en_n ? scan_cnt_n[NB-1:0] : '0;
      done         <= (state_n == FIN);
      busy         <= (state_n != IDLE);

      // Running max restarts at zero on every scan entry.
      if (in_srch_n && (state_n != state)) begin
        run_max <= '0;
        run_bin <= '0;
      end else if (in_srch) begin
        run_max <= cand_max;
        run_bin <= cand_bin;
      end

      // Publish the scan result only on a normal scan exit.
      if (in_srch && (state_n == CALC || state_n == FIN)) begin
        peak_bin <= cand_bin;
        peak_cnt <= cand_max;
      end

      if (state == CALC && state_n == CLR_F) begin
        win_lo <= calc_lo;
        win_hi <= calc_lo + FINE_SPAN;
      end

      if ((state == IDLE && state_n == CLR_C) || (abort && state != IDLE)) begin
        tof       <= '0;
        tof_valid <= 1'b0;
        no_target <= 1'b0;
      end else if (state == CALC && state_n == FIN) begin
        no_target <= 1'b1;
      end else if (state == SRCH_F && state_n == FIN) begin
        tof       <= win_lo + NP'(cand_bin);
        tof_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sifh_zoom_controller.sv
// Directed bench for sifh_zoom_controller with a histogram memory model,
// a clear-acknowledge responder and a result scoreboard.
module tb_sifh_zoom_controller;
  localparam int NP = 10;
  localparam int NB = 4;
  localparam int CW = 16;

  // Clock and reset signals
  logic          clk = 1'b0;
  logic          rst, start, abort, frame_tick;
  logic          hist_clr, hist_clr_done, hist_en, fine_mode;
  logic [NP-1:0] win_lo, win_hi, tof;
  logic          hist_rd_en, tof_valid, no_target, done, busy;
  logic [NB-1:0] hist_rd_addr, peak_bin;
  logic [CW-1:0] hist_rd_data, peak_cnt;
  logic [3:0]    dbg_state;

  always #5 clk = ~clk;

  sifh_zoom_controller #(.NP(NP), .NB(NB), .CW(CW), .N_COARSE(4), .N_FINE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_tick(frame_tick),
    .hist_clr(hist_clr), .hist_clr_done(hist_clr_done), .hist_en(hist_en),
    .fine_mode(fine_mode), .win_lo(win_lo), .win_hi(win_hi),
    .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data),
    .peak_bin(peak_bin), .peak_cnt(peak_cnt), .tof(tof), .tof_valid(tof_valid),
    .no_target(no_target), .done(done), .busy(busy), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Histogram memory and responders
  logic [CW-1:0] coarse_mem [16];
  logic [CW-1:0] fine_mem [16];
  logic          resp_done = 1'b0;
  logic          man_done = 1'b0;
  int            clr_dly = 0;
  logic          tick_on = 1'b0;
  int            tick_div = 0;

  assign hist_clr_done = resp_done | man_done;

  always @(posedge clk)
    hist_rd_data <= fine_mode ? fine_mem[hist_rd_addr] : coarse_mem[hist_rd_addr];

  // Acknowledge each clear request three cycles later.
  always @(negedge clk) begin
    resp_done = 1'b0;
    if (hist_clr) clr_dly = 3;
    else if (clr_dly != 0) begin
      clr_dly--;
      if (clr_dly == 0) resp_done = 1'b1;
    end
  end

  // Laser frame ticks every fourth cycle.
  always @(negedge clk) begin
    frame_tick = 1'b0;
    if (tick_on) begin
      tick_div++;
      frame_tick = (tick_div % 4 == 0);
    end
  end

  // Activity monitors
  int            en_ticks = 0, rd_cnt = 0, addr_bad = 0, srch_cycles = 0;
  int            clr_pulses = 0, done_cnt = 0, sb_underflow = 0;
  logic          fine_seen = 1'b0;
  logic [NB-1:0] rd_expect = '0;

  always @(posedge clk) begin
    if (frame_tick && hist_en) en_ticks++;
    if (dbg_state == 4'd3 || dbg_state == 4'd7) srch_cycles++;
    if (hist_rd_en) begin
      if (hist_rd_addr != rd_expect) addr_bad++;
      rd_expect = rd_expect + 1'b1;
      rd_cnt++;
    end
  end

  // Scoreboard: each expected completion is {no_target, tof_valid, tof}.
  logic [NP+1:0] exp_q [$];
  logic [NP+1:0] sb_exp;

  always @(negedge clk) begin
    if (!rst) begin
      if (fine_mode) fine_seen = 1'b1;
      if (hist_clr) clr_pulses++;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) sb_underflow++;
        else begin
          sb_exp = exp_q.pop_front();
          check("sb_result", {no_target, tof_valid, tof}, sb_exp);
        end
      end
    end
  end

  // Driver tasks
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_stats();
    en_ticks = 0; rd_cnt = 0; addr_bad = 0; srch_cycles = 0;
    clr_pulses = 0; done_cnt = 0; fine_seen = 1'b0; rd_expect = '0;
  endtask

  task automatic wait_fine(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (fine_mode) break;
      @(negedge clk);
    end
    check({tag, "_fine_reached"}, fine_mode, 1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 600; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check({tag, "_done_reached"}, done, 1);
    @(negedge clk);
  endtask

  task automatic run_full(input string tag, input logic [NP-1:0] e_lo, input logic [NP-1:0] e_hi,
                          input logic [NB-1:0] e_cbin, input logic [NP-1:0] e_tof,
                          input logic [NB-1:0] e_fbin, input bit mid_start);
    clear_stats();
    exp_q.push_back({1'b0, 1'b1, e_tof});
    pulse_start();
    if (mid_start) begin
      for (int i = 0; i < 200; i++) begin
        if (en_ticks >= 1) break;
        @(negedge clk);
      end
      pulse_start();
    end
    wait_fine(tag);
    check({tag, "_coarse_ticks"}, en_ticks, 4);
    check({tag, "_coarse_peak"}, peak_bin, e_cbin);
    check({tag, "_win_lo"}, win_lo, e_lo);
    check({tag, "_win_hi"}, win_hi, e_hi);
    wait_done(tag);
    check({tag, "_fine_peak"}, peak_bin, e_fbin);
    check({tag, "_total_ticks"}, en_ticks, 8);
    check({tag, "_rd_count"}, rd_cnt, 32);
    check({tag, "_srch_cycles"}, srch_cycles, 34);
    check({tag, "_rd_addr_seq"}, addr_bad, 0);
    check({tag, "_clr_pulses"}, clr_pulses, 2);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 16; i++) begin coarse_mem[i] = '0; fine_mem[i] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset state, idle ignores ticks and stray acknowledges
    check("rst_flags", {hist_clr, hist_en, fine_mode, hist_rd_en, tof_valid, no_target, done, busy}, 0);
    check("rst_win_lo", win_lo, 0);
    check("rst_win_hi", win_hi, 0);
    check("rst_tof", tof, 0);
    check("rst_peak_bin", peak_bin, 0);
    check("rst_peak_cnt", peak_cnt, 0);
    check("rst_rd_addr", hist_rd_addr, 0);
    clear_stats();
    tick_on = 1'b1;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (12) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_activity", {hist_clr, hist_en, hist_rd_en, done}, 0);
    check("idle_ticks_ignored", en_ticks + clr_pulses + rd_cnt, 0);

    // 2: clear coarse peak at bin 5, fine peak at bin 7
    for (int i = 0; i < 16; i++) begin
      coarse_mem[i] = CW'($urandom_range(0, 10));
      fine_mem[i]   = CW'($urandom_range(0, 30));
    end
    coarse_mem[5] = 16'd100;
    fine_mem[7]   = 16'd40;
    run_full("t2", 10'd344, 10'd359, 4'd5, 10'd351, 4'd7, 1'b0);
    check("t2_peak_cnt", peak_cnt, 40);

    // 3: coarse tie keeps lowest index, fine tie likewise
    for (int i = 0; i < 16; i++) begin coarse_mem[i] = '0; fine_mem[i] = '0; end
    coarse_mem[3] = 16'd50; coarse_mem[9] = 16'd50;
    fine_mem[2] = 16'd9; fine_mem[11] = 16'd9;
    run_full("t3", 10'd216, 10'd231, 4'd3, 10'd218, 4'd2, 1'b0);

    // 4: empty coarse histogram -> no target
    for (int i = 0; i < 16; i++) coarse_mem[i] = '0;
    clear_stats();
    exp_q.push_back({1'b1, 1'b0, 10'd0});
    pulse_start();
    wait_done("t4");
    check("t4_clr_once", clr_pulses, 1);
    check("t4_fine_never", fine_seen, 0);
    check("t4_rd_count", rd_cnt, 16);
    check("t4_peak_cnt", peak_cnt, 0);
    check("t4_peak_bin", peak_bin, 0);

    // 5: abort two cycles into the fine accumulation
    for (int i = 0; i < 16; i++) begin
      coarse_mem[i] = CW'($urandom_range(0, 10));
      fine_mem[i]   = CW'($urandom_range(0, 30));
    end
    coarse_mem[5] = 16'd100;
    fine_mem[7]   = 16'd40;
    clear_stats();
    pulse_start();
    wait_fine("t5");
    for (int i = 0; i < 100; i++) begin
      if (hist_en) break;
      @(negedge clk);
    end
    check("t5_acc_f_reached", hist_en, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_abort_flags", {hist_en, hist_rd_en, hist_clr, fine_mode, busy, done}, 0);
    check("t5_abort_tof", {no_target, tof_valid, tof}, 0);
    repeat (40) @(negedge clk);
    check("t5_no_done", done_cnt, 0);
    check("t5_idle_after", busy, 0);
    run_full("t5b", 10'd344, 10'd359, 4'd5, 10'd351, 4'd7, 1'b1);

    // 6: top bin in both passes
    for (int i = 0; i < 16; i++) begin
      coarse_mem[i] = CW'($urandom_range(0, 100));
      fine_mem[i]   = CW'($urandom_range(0, 20));
    end
    coarse_mem[15] = 16'd200;
    fine_mem[15]   = 16'd30;
    run_full("t6", 10'd984, 10'd999, 4'd15, 10'd999, 4'd15, 1'b0);

    check("sb_underflow", sb_underflow, 0);
    check("sb_leftover", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
